game_screen_ctrl: RTL and testbench



---
 rtl/game_screen_ctrl_if.sv | 14 +
 rtl/game_screen_ctrl.sv | 123 ++++++++++++
 tb/tb_game_screen_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_screen_ctrl_if.sv
// VGA stream bundle: cycle-aligned timing fields plus 12-bit colour.
// "in" is the consumer view and "out" is the producer view.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/game_screen_ctrl.sv
// Game-flow FSM (START/PLAY/FINISH) choosing which screen's rgb reaches the
// output register; screen changes land only on a vblank rising edge.
module game_screen_ctrl #(
  parameter int FINISH_FRAMES = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       game_over,
  vga_if.in          vga_start,
  vga_if.in          vga_game,
  vga_if.in          vga_finish,
  vga_if.out         vga_out,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_PLAY   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [11:0] LAST_FRAME = 12'(FINISH_FRAMES - 1);

  state_t      state_q, state_d;
  logic [11:0] frame_cnt, frame_cnt_d;
  logic        sync1, sync2, sync3;
  logic        vblnk_d;
  logic        start_pend, over_pend;
  logic        start_edge, frame_tick, start_req, over_req;

  // Two flops tame the asynchronous button; the third gives the edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      vblnk_d <= 1'b0;
    end else begin
      sync1   <= start_btn;
      sync2   <= sync1;
      sync3   <= sync2;
      vblnk_d <= vga_start.vblnk;
    end
  end

  assign start_edge = sync2 & ~sync3;
  assign frame_tick = vga_start.vblnk & ~vblnk_d;

  // A request arriving in the tick cycle itself still counts for that tick.
  assign start_req = start_pend | (start_edge & (state_q != ST_PLAY));
  assign over_req  = over_pend  | (game_over  & (state_q == ST_PLAY));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_START;
      frame_cnt <= '0;
    end else begin
      state_q   <= state_d;
      frame_cnt <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt;
    if (frame_tick) begin
      case (state_q)
        ST_START: if (start_req) state_d = ST_PLAY;
        ST_PLAY: begin
          if (over_req) begin
            state_d     = ST_FINISH;
            frame_cnt_d = '0;
          end
        end
        ST_FINISH: begin
          if (start_req)                    state_d = ST_PLAY;
          else if (frame_cnt == LAST_FRAME) state_d = ST_START;
          else                              frame_cnt_d = frame_cnt + 12'd1;
        end
        default: state_d = ST_START;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state_d != state_q)) begin
      start_pend <= 1'b0;
      over_pend  <= 1'b0;
    end else begin
      start_pend <= start_req;
      over_pend  <= over_req;
    end
  end

  // Timing always follows the start stream; only colour is switched.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.vcount <= '0;
      vga_out.vsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.vcount <= vga_start.vcount;
      vga_out.vsync  <= vga_start.vsync;
      vga_out.vblnk  <= vga_start.vblnk;
      vga_out.hcount <= vga_start.hcount;
      vga_out.hsync  <= vga_start.hsync;
      vga_out.hblnk  <= vga_start.hblnk;
      case (state_q)
        ST_PLAY:   vga_out.rgb <= vga_game.rgb;
        ST_FINISH: vga_out.rgb <= vga_finish.rgb;
        default:   vga_out.rgb <= vga_start.rgb;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Bench for game_screen_ctrl: a small synthetic VGA raster, scenario tasks
// with inline checks, and a frame-level reference model checking every cycle.
module tb_game_screen_ctrl;

  localparam int FF       = 3;
  localparam int H_TOTAL  = 20;
  localparam int H_BLANK  = 16;
  localparam int V_TOTAL  = 12;
  localparam int V_BLANK  = 10;
  localparam int MID_LINE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] state;

  vga_if s_start ();
  vga_if s_game ();
  vga_if s_finish ();
  vga_if s_out ();

  int n_checks = 0;
  int n_pass   = 0;
  int cur_hc   = 0;
  int cur_vc   = 0;

  // reference model (frame-level game rules)
  int          mdl_state = 0;
  int          m_cnt     = 0;
  bit          m_start   = 1'b0;
  bit          m_over    = 1'b0;
  bit          m_vb_prev = 1'b0;
  bit          m_btn_prev = 1'b0;
  bit          exp_zero  = 1'b1;
  int          prev_sel  = 0;
  logic [25:0] prev_t    = '0;
  logic [11:0] prev_rs   = '0;
  logic [11:0] prev_rg   = '0;
  logic [11:0] prev_rf   = '0;
  logic [25:0] got_t, exp_t;
  logic [11:0] exp_rgb;
  bit          m_tick;

  game_screen_ctrl #(.FINISH_FRAMES(FF)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .game_over (game_over),
    .vga_start (s_start),
    .vga_game  (s_game),
    .vga_finish(s_finish),
    .vga_out   (s_out),
    .state     (state)
  );

  // ---------------- clock / raster generator ----------------
  always #5 clk = ~clk;

  task automatic set_stream();
    s_start.vcount = 11'(cur_vc);
    s_start.hcount = 11'(cur_hc);
    s_start.vblnk  = (cur_vc >= V_BLANK);
    s_start.vsync  = (cur_vc == V_TOTAL - 1);
    s_start.hblnk  = (cur_hc >= H_BLANK);
    s_start.hsync  = (cur_hc == 17) || (cur_hc == 18);
    s_start.rgb    = 12'($urandom);
    s_game.rgb     = 12'($urandom);
    s_finish.rgb   = 12'($urandom);
    s_game.vcount = '0; s_game.hcount = '0; s_game.vblnk = 1'b0;
    s_game.vsync = 1'b0; s_game.hblnk = 1'b0; s_game.hsync = 1'b0;
    s_finish.vcount = '0; s_finish.hcount = '0; s_finish.vblnk = 1'b0;
    s_finish.vsync = 1'b0; s_finish.hblnk = 1'b0; s_finish.hsync = 1'b0;
  endtask

  initial begin
    set_stream();
    forever begin
      @(posedge clk); #1;
      if (cur_hc == H_TOTAL - 1) begin
        cur_hc = 0;
        cur_vc = (cur_vc == V_TOTAL - 1) ? 0 : cur_vc + 1;
      end else begin
        cur_hc = cur_hc + 1;
      end
      set_stream();
    end
  end

  // ---------------- scoreboard: per-cycle output check + model ----------------
  always @(negedge clk) begin
    got_t = {s_out.vcount, s_out.vsync, s_out.vblnk, s_out.hcount, s_out.hsync, s_out.hblnk};
    if (exp_zero) begin
      exp_t   = '0;
      exp_rgb = '0;
    end else begin
      exp_t   = prev_t;
      exp_rgb = (prev_sel == 1) ? prev_rg : (prev_sel == 2) ? prev_rf : prev_rs;
    end
    n_checks++;
    if (got_t !== exp_t) $display("FAIL stream_timing @%0t: got=%h expected=%h", $time, got_t, exp_t);
    else n_pass++;
    n_checks++;
    if (s_out.rgb !== exp_rgb) $display("FAIL stream_rgb @%0t: got=%h expected=%h", $time, s_out.rgb, exp_rgb);
    else n_pass++;
    n_checks++;
    if (state !== 2'(mdl_state)) $display("FAIL model_state @%0t: got=%0d expected=%0d", $time, state, mdl_state);
    else n_pass++;

    prev_t   = {s_start.vcount, s_start.vsync, s_start.vblnk, s_start.hcount, s_start.hsync, s_start.hblnk};
    prev_rs  = s_start.rgb;
    prev_rg  = s_game.rgb;
    prev_rf  = s_finish.rgb;
    prev_sel = mdl_state;

    if (rst) begin
      exp_zero   = 1'b1;
      mdl_state  = 0;
      m_cnt      = 0;
      m_start    = 1'b0;
      m_over     = 1'b0;
      m_vb_prev  = 1'b0;
      m_btn_prev = 1'b0;
    end else begin
      exp_zero = 1'b0;
      if (start_btn && !m_btn_prev && mdl_state != 1) m_start = 1'b1;
      m_btn_prev = start_btn;
      if (game_over && mdl_state == 1) m_over = 1'b1;
      m_tick    = s_start.vblnk && !m_vb_prev;
      m_vb_prev = s_start.vblnk;
      if (m_tick) begin
        if (mdl_state == 0 && m_start) begin
          mdl_state = 1; m_start = 1'b0; m_over = 1'b0;
        end else if (mdl_state == 1 && m_over) begin
          mdl_state = 2; m_cnt = 0; m_start = 1'b0; m_over = 1'b0;
        end else if (mdl_state == 2) begin
          if (m_start) begin
            mdl_state = 1; m_start = 1'b0; m_over = 1'b0;
          end else if (m_cnt == FF - 1) begin
            mdl_state = 0; m_start = 1'b0; m_over = 1'b0;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press_start();
    @(posedge clk); #1 start_btn = 1'b1;
    repeat (10) @(posedge clk);
    #1 start_btn = 1'b0;
  endtask

  task automatic pulse_over();
    @(posedge clk); #1 game_over = 1'b1;
    @(posedge clk); #1 game_over = 1'b0;
  endtask

  task automatic wait_mid();
    bit found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk); #1;
      if (cur_vc == MID_LINE && cur_hc == 0) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      $display("FAIL wait_mid: mid-frame line not reached within 600 cycles");
    end
  endtask

  task automatic wait_tick();
    bit found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk); #1;
      if (cur_vc == V_BLANK && cur_hc == 0) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      $display("FAIL wait_tick: no frame tick within 600 cycles");
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (4) @(posedge clk);
    step();
    n_checks++;
    if (state !== 2'd0) $display("FAIL reset_state: got=%0d expected=0", state); else n_pass++;
    n_checks++;
    if ({s_out.vcount, s_out.vsync, s_out.vblnk, s_out.hcount, s_out.hsync, s_out.hblnk, s_out.rgb} !== 38'd0)
      $display("FAIL reset_outputs: got rgb=%h vcount=%0d hcount=%0d expected all 0", s_out.rgb, s_out.vcount, s_out.hcount);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2 * H_TOTAL * V_TOTAL) @(posedge clk);
    step();
    n_checks++;
    if (state !== 2'd0) $display("FAIL idle_state: got=%0d expected=0", state); else n_pass++;
  endtask

  task automatic test_start();
    bit          early = 1'b0;
    bit          found = 1'b0;
    logic [11:0] g;
    wait_mid();
    press_start();
    for (int k = 0; k < 600 && !found; k++) begin
      step();
      if (state !== 2'd0) early = 1'b1;
      if (cur_vc == V_BLANK && cur_hc == 0) found = 1'b1;
    end
    n_checks++;
    if (early || !found) $display("FAIL start_early: early=%0d tick_found=%0d expected 0/1", early, found);
    else n_pass++;
    step();
    n_checks++;
    if (state !== 2'd1) $display("FAIL start_enter: got=%0d expected=1", state); else n_pass++;
    g = s_game.rgb;
    step();
    n_checks++;
    if (s_out.rgb !== g) $display("FAIL start_rgb_switch: got=%h expected=%h", s_out.rgb, g); else n_pass++;
  endtask

  task automatic test_game_over();
    wait_mid();
    pulse_over();
    wait_tick();
    n_checks++;
    if (state !== 2'd1) $display("FAIL over_hold: got=%0d expected=1", state); else n_pass++;
    step();
    n_checks++;
    if (state !== 2'd2) $display("FAIL over_enter: got=%0d expected=2", state); else n_pass++;
    for (int t = 1; t <= 2; t++) begin
      wait_tick();
      step();
      n_checks++;
      if (state !== 2'd2) $display("FAIL finish_hold_tick%0d: got=%0d expected=2", t, state); else n_pass++;
    end
    wait_tick();
    n_checks++;
    if (state !== 2'd2) $display("FAIL finish_before_timeout: got=%0d expected=2", state); else n_pass++;
    step();
    n_checks++;
    if (state !== 2'd0) $display("FAIL finish_timeout: got=%0d expected=0", state); else n_pass++;
  endtask

  task automatic test_restart_priority();
    wait_mid(); press_start(); wait_tick(); step();
    wait_mid(); pulse_over(); wait_tick(); step();
    n_checks++;
    if (state !== 2'd2) $display("FAIL prio_setup: got=%0d expected=2", state); else n_pass++;
    wait_tick();
    wait_tick();
    wait_mid();
    press_start();
    wait_tick();
    step();
    n_checks++;
    if (state !== 2'd1) $display("FAIL restart_priority: got=%0d expected=1", state); else n_pass++;
  endtask

  task automatic test_play_events();
    wait_mid();
    press_start();
    repeat (20) @(posedge clk);
    pulse_over();
    wait_tick();
    step();
    n_checks++;
    if (state !== 2'd2) $display("FAIL play_both: got=%0d expected=2", state); else n_pass++;
    wait_mid(); press_start(); wait_tick(); step();
    for (int f = 0; f < 3; f++) begin
      wait_mid();
      press_start();
      wait_tick();
      step();
      n_checks++;
      if (state !== 2'd1) $display("FAIL play_start_ignored_f%0d: got=%0d expected=1", f, state); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    wait_mid(); pulse_over(); wait_tick();
    wait_tick();
    wait_tick();
    wait_mid();
    press_start();
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    step();
    n_checks++;
    if (state !== 2'd0) $display("FAIL rst_mid_state: got=%0d expected=0", state); else n_pass++;
    n_checks++;
    if ({s_out.vcount, s_out.vsync, s_out.vblnk, s_out.hcount, s_out.hsync, s_out.hblnk, s_out.rgb} !== 38'd0)
      $display("FAIL rst_mid_outputs: got rgb=%h vcount=%0d hcount=%0d expected all 0", s_out.rgb, s_out.vcount, s_out.hcount);
    else n_pass++;
    wait_tick();
    step();
    n_checks++;
    if (state !== 2'd0) $display("FAIL rst_mid_pend_lost: got=%0d expected=0", state); else n_pass++;
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 20; i++) begin
      op = $urandom_range(0, 3);
      wait_mid();
      if (op == 1 || op == 3) press_start();
      if (op == 3) repeat (20) @(posedge clk);
      if (op == 2 || op == 3) pulse_over();
      wait_tick();
      step();
      n_checks++;
      if (state !== 2'(mdl_state)) $display("FAIL random_frame%0d: got=%0d expected=%0d", i, state, mdl_state);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_game_over();
    test_restart_priority();
    test_play_events();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
